inv_mix_col_seq: RTL and testbench
==================================

// Module: inv_mix_col_seq
// PURPOSE
//   Sequencer for the AES decryption InvMixColumns step built on the shared registered GF(2^8) LUTs.
//   Instantiates LANES column lanes. Each lane holds 4x lut_mult_9, lut_mult_11, lut_mult_13, lut_mult_14
//   (8-bit addr in, product registered on posedge clk).
//   Feeds the 4 state columns through the lanes over 4/LANES cycles, XOR-combines products and assembles the 128-bit result.
//   Sits between InvSubBytes/AddRoundKey and the round register in the decryption round loop; valid/ready on both sides.
// PARAMETERS
//   LANES  1  column lanes of multipliers; legal values 1, 2, 4 (others: elaboration error)
// PORTS
//   clk        in   1    single clock, all state on posedge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    in_state/in_skip valid
//   in_ready   out  1    block idle, can accept
//   in_state   in   128  state; column c = [127-32c -: 32], row r of column = [31-8r -: 8] within it
//   in_skip    in   1    final-round bypass: output = input, same latency
//   out_valid  out  1    out_state valid, held until accepted
//   out_ready  in   1    downstream accepts
//   out_state  out  128  InvMixColumns(in_state) (or in_state if skipped)
//   busy       out  1    high in any state but IDLE
// BEHAVIOUR
//   Reset (async, any state): FSM->IDLE, column counter 0, out_state 0, out_valid 0, in_ready 1 after release, busy 0.
//   FSM: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//   - IDLE: in_ready=1; on in_valid&in_ready, capture in_state/in_skip into the input register; ->FEED, col=0.
//   - FEED: present columns col..col+LANES-1 to the lanes; col += LANES.
//     After 4/LANES cycles ->DRAIN. Products arrive 1 cycle after presentation (LUT latency).
//   - Write-back: columns presented in cycle k are combined and written into out_state at the end of cycle k+1.
//     This overlaps with the next FEED cycle; the last write occurs in DRAIN.
//   - Combine per column a0..a3 -> r0..r3:
//     - r0 = 14a0^11a1^13a2^9a3
//     - r1 = 9a0^14a1^11a2^13a3
//     - r2 = 13a0^9a1^14a2^11a3
//     - r3 = 11a0^13a1^9a2^14a3
//     Pure XOR, 8-bit; no carries.
//   - Skip: LUTs still clocked; the write-back selects the delayed raw column instead of the XOR result.
//   - DONE: out_valid=1, out_state stable; on out_ready ->IDLE (out_valid drops next cycle).
//     in_ready stays 0 in DONE even if out_ready=1, i.e. no same-cycle turnaround.
//   Latency: accept edge to out_valid = 4/LANES+1 cycles (LANES=1: 5, 2: 3, 4: 2).
//   Min spacing between accepts = 4/LANES+3 cycles with out_ready tied high.
//   in_valid while busy: ignored (in_ready=0); upstream must hold it. Input register changes only on the accept edge.
//   out_ready while out_valid=0: no effect.
//   Reset mid-FEED/DRAIN/DONE: operation aborted, partial out_state cleared to 0, no out_valid pulse.
//   out_state is not cleared on accept; it holds the last result until the next write-back.
//   Column counter wraps to 0 only through DRAIN/IDLE; never exceeds 4-LANES.
// TESTING
//   1. in_state={8e4da1bc,9fdc589d,01010101,c6c6c6c6}, skip=0, LANES=1
//      -> out_state={db135345,f20a225c,01010101,c6c6c6c6}; out_valid exactly 5 cycles after accept.
//   2. Same input with skip=1 -> out_state equals in_state, same 5-cycle latency.
//   3. out_ready=0 for 10 cycles after out_valid -> out_valid/out_state stable, in_ready=0;
//      out_ready=1 -> next cycle IDLE, in_ready=1.
//   4. Back-to-back inputs, in_valid held high, out_ready=1
//      -> accepts spaced 7 cycles apart, both results correct, second input not captured early.
//   5. Assert rst in the 3rd FEED cycle -> out_valid stays 0, out_state=0, in_ready=1 after release;
//      the next transfer is correct.
//   6. Repeat test 1 with LANES=2 and LANES=4 -> same results at latency 3 and 2;
//      also all-zero state -> all-zero output.

Source files
------------

// File: rtl/inv_mix_col_seq_if.sv
// Handshake bundle for the InvMixColumns sequencer: input side, output side, status.
// The master drives in_*/out_ready; the slave (the sequencer) drives the rest.
// Both sides use valid/ready; out_valid is held until out_ready.
interface inv_mix_col_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_skip;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_skip, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_skip, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_mix_col_seq.sv
// AES InvMixColumns sequencer: columns are streamed through LANES lanes of registered GF(2^8) multipliers.
// Latency: accept edge to out_valid = 4/LANES+1 cycles.
// Backpressure: single transaction in flight; in_ready low while busy, out_valid held until out_ready.
module inv_mix_col_seq #(
  parameter int LANES = 1
) (
  input logic            clk,
  input logic            rst,
  inv_mix_col_seq_if.slave bus
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("inv_mix_col_seq: LANES must be 1, 2 or 4");
  end

  // Last column index presented by lane 0, and the per-cycle advance.
  localparam logic [1:0] COL_LAST = 2'(4 - LANES);
  localparam logic [1:0] COL_STEP = 2'(LANES);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] in_reg;
  logic         skip_q;
  logic         wb_vld_q;
  logic [1:0]   wb_col_q;
  logic [31:0]  out_col_q [4];
  logic [31:0]  in_col    [4];
  logic [31:0]  lane_res  [LANES];
  logic         in_ready_c, out_valid_c, busy_c;

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign in_col[c] = in_reg[127-32*c -: 32];
  end

  // Each lane: registered x9/x11/x13/x14 per row, plus the raw column delayed to match.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] a;
    logic [7:0]  p9 [4];
    logic [7:0]  p11 [4];
    logic [7:0]  p13 [4];
    logic [7:0]  p14 [4];
    logic [31:0] raw_q;
    logic [31:0] mix;

    assign a = in_col[col_q + 2'(l)];

    // Multiplier product registers; clocked every cycle regardless of skip.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        raw_q <= '0;
        for (int r = 0; r < 4; r++) begin
          p9[r]  <= '0;
          p11[r] <= '0;
          p13[r] <= '0;
          p14[r] <= '0;
        end
      end else begin
        raw_q <= a;
        for (int r = 0; r < 4; r++) begin
          p9[r]  <= mul9(a[31-8*r -: 8]);
          p11[r] <= mul11(a[31-8*r -: 8]);
          p13[r] <= mul13(a[31-8*r -: 8]);
          p14[r] <= mul14(a[31-8*r -: 8]);
        end
      end
    end

    assign mix = {p14[0] ^ p11[1] ^ p13[2] ^ p9[3],
                  p9[0]  ^ p14[1] ^ p11[2] ^ p13[3],
                  p13[0] ^ p9[1]  ^ p14[2] ^ p11[3],
                  p11[0] ^ p13[1] ^ p9[2]  ^ p14[3]};

    assign lane_res[l] = skip_q ? raw_q : mix;
  end

  // State and column counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Next-state, column advance and handshake outputs.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        col_d      = '0;
        if (bus.in_valid) state_d = FEED;
      end
      FEED: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = DRAIN;
        end else begin
          col_d = col_q + COL_STEP;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input register loads only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg <= '0;
      skip_q <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid) begin
      in_reg <= bus.in_state;
      skip_q <= bus.in_skip;
    end
  end

  // Write-back: columns presented last cycle land in out_state one cycle after their products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_q <= 1'b0;
      wb_col_q <= '0;
      for (int c = 0; c < 4; c++) out_col_q[c] <= '0;
    end else begin
      wb_vld_q <= (state_q == FEED);
      wb_col_q <= col_q;
      if (wb_vld_q) begin
        for (int l = 0; l < LANES; l++) out_col_q[wb_col_q + 2'(l)] <= lane_res[l];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_state = {out_col_q[0], out_col_q[1], out_col_q[2], out_col_q[3]};

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Directed bench for inv_mix_col_seq: LANES=1, 2 and 4 instances share one stimulus stream.
// Checks latency, results, skip, hold under backpressure, back-to-back spacing and mid-op reset.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_inv_mix_col_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_skip;
  logic         out_ready;
  int           n_run;
  int           n_fail;

  localparam logic [127:0] VA  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VAR = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VB  = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] VBR = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;

  inv_mix_col_seq_if i1 ();
  inv_mix_col_seq_if i2 ();
  inv_mix_col_seq_if i4 ();

  assign i1.in_valid = in_valid;  assign i1.in_state = in_state;
  assign i1.in_skip  = in_skip;   assign i1.out_ready = out_ready;
  assign i2.in_valid = in_valid;  assign i2.in_state = in_state;
  assign i2.in_skip  = in_skip;   assign i2.out_ready = out_ready;
  assign i4.in_valid = in_valid;  assign i4.in_state = in_state;
  assign i4.in_skip  = in_skip;   assign i4.out_ready = out_ready;

  inv_mix_col_seq #(.LANES(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  inv_mix_col_seq #(.LANES(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
  inv_mix_col_seq #(.LANES(4)) u4 (.clk(clk), .rst(rst), .bus(i4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_skip   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", i1.out_valid, 1'b0);
    chk("rst_out_state", i1.out_state, '0);
    chk("rst_in_ready",  i1.in_ready,  1'b1);
    chk("rst_busy",      i1.busy,      1'b0);

    // Test 1 (and LANES=2/4 of test 6): known vector, latency 5/3/2, held by out_ready=0
    in_valid = 1'b1; in_state = VA; in_skip = 1'b0;
    chk("t1_in_ready", i1.in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_busy", i1.busy, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1_vld_l1_c%0d", k), i1.out_valid, k == 5);
      chk($sformatf("t1_vld_l2_c%0d", k), i2.out_valid, k >= 3);
      chk($sformatf("t1_vld_l4_c%0d", k), i4.out_valid, k >= 2);
    end
    chk("t1_state_l1", i1.out_state, VAR);
    chk("t6_state_l2", i2.out_state, VAR);
    chk("t6_state_l4", i4.out_state, VAR);

    // Test 3: backpressure for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_vld",   i1.out_valid, 1'b1);
      chk("t3_hold_state", i1.out_state, VAR);
      chk("t3_hold_rdy",   i1.in_ready,  1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_rel_in_ready",  i1.in_ready,  1'b1);
    chk("t3_rel_out_valid", i1.out_valid, 1'b0);
    chk("t3_rel_busy",      i1.busy,      1'b0);
    chk("t3_rel_state",     i1.out_state, VAR);

    // Test 2: skip returns the input unchanged at the same latency
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = VA; in_skip = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_skip = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_vld_c%0d", k), i1.out_valid, k == 5);
    end
    chk("t2_state_l1", i1.out_state, VA);
    chk("t2_state_l2", i2.out_state, VA);
    chk("t2_state_l4", i4.out_state, VA);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Test 4: back-to-back with in_valid held, second word presented right after the first accept
    in_valid = 1'b1; in_state = VA;
    chk("t4_rdy0", i1.in_ready, 1'b1);
    @(negedge clk);
    in_state = VB;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 4)  chk("t4_a_vld_early", i1.out_valid, 1'b0);
      if (n == 5) begin
        chk("t4_a_vld",   i1.out_valid, 1'b1);
        chk("t4_a_state", i1.out_state, VAR);
        chk("t4_a_rdy",   i1.in_ready,  1'b0);
      end
      if (n == 6) begin
        chk("t4_gap_rdy", i1.in_ready,  1'b1);
        chk("t4_gap_vld", i1.out_valid, 1'b0);
      end
      if (n == 7) begin
        chk("t4_b_acc_busy", i1.busy, 1'b1);
        in_valid = 1'b0;
      end
      if (n == 11) chk("t4_b_vld_early", i1.out_valid, 1'b0);
      if (n == 12) begin
        chk("t4_b_vld",   i1.out_valid, 1'b1);
        chk("t4_b_state", i1.out_state, VBR);
      end
    end
    repeat (2) @(negedge clk);

    // Test 5: reset during the third FEED cycle
    in_valid = 1'b1; in_state = VA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_state", i1.out_state, '0);
    chk("t5_rst_vld",   i1.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rdy",   i1.in_ready,  1'b1);
    chk("t5_post_busy",  i1.busy,      1'b0);
    chk("t5_post_state", i1.out_state, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_vld", i1.out_valid, 1'b0);
    end
    in_valid = 1'b1; in_state = VA;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_vld_c%0d", k), i1.out_valid, k == 5);
    end
    chk("t5_state", i1.out_state, VAR);
    repeat (2) @(negedge clk);

    // Test 6: all-zero state on every lane count
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_zero_vld_l1", i1.out_valid, 1'b1);
    chk("t6_zero_l1", i1.out_state, '0);
    chk("t6_zero_l2", i2.out_state, '0);
    chk("t6_zero_l4", i4.out_state, '0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
